tt_um_multichannel_pwm: RTL

- Tiny Tapeout user-project top with the standard `tt_um_*` pin interface.
- Generates up to 7 independent PWM channels from one shared, prescaled period counter.
- Duty values and a control register are written byte-wise through `ui_in`, strobed by `uio_in`.
- Duty updates are double-buffered and applied only at period wrap, so outputs never glitch mid-period.

---
 rtl/tt_um_multichannel_pwm_pkg.sv | 20 ++
 rtl/tt_um_multichannel_pwm_if.sv | 12 +
 rtl/tt_um_multichannel_pwm_sync.sv | 26 ++
 rtl/tt_um_multichannel_pwm.sv | 123 ++++++++++++
 4 files changed

// File: rtl/tt_um_multichannel_pwm_pkg.sv
// Shared constants and helpers for the multichannel PWM block.
package pwm_pkg;
    localparam logic [2:0] ADDR_CTRL    = 3'd7;
    localparam int         CTRL_EN_BIT  = 7;
    localparam int         CTRL_PRE_MSB = 3;

    localparam logic [7:0] UIO_OE_VAL = 8'hE0;
    localparam int         UIO_WRAP   = 5;
    localparam int         UIO_ACK    = 6;
    localparam int         UIO_HB     = 7;

    // Left-justify the byte in a 12-bit field, then shift so the top `width`
    // bits land at the bottom: pads with zeros for width >= 8, keeps the
    // byte's MSBs for width < 8. Caller keeps bits [width-1:0].
    function automatic logic [11:0] scale_duty(input logic [7:0] b, input int width);
        logic [11:0] full;
        full = {b, 4'b0000};
        return full >> (12 - width);
    endfunction
endpackage

// File: rtl/tt_um_multichannel_pwm_if.sv
// Bundle of the Tiny Tapeout user pins (minus clk/rst_n) used by a harness.
interface tt_um_multichannel_pwm_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;

    modport master (output ena, ui_in, uio_in, input uio_out, uio_oe, uo_out);
    modport slave  (input ena, ui_in, uio_in, output uio_out, uio_oe, uo_out);
endinterface

// File: rtl/tt_um_multichannel_pwm_sync.sv
// Synchroniser chain for an asynchronous level strobe plus a one-cycle
// rising-edge pulse on the synchronised signal.
module strobe_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   last;

    // Shift the raw strobe through the chain and remember the previous output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            last <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], strobe};
            last <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~last;
endmodule

// File: rtl/tt_um_multichannel_pwm.sv
// Multichannel PWM: shared prescaled period counter, byte-wise register
// writes via a synchronised strobe, duty double-buffered to the period wrap.
module tt_um_multichannel_pwm
    import pwm_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);
    localparam logic [WIDTH-1:0] DUTY_MAX = '1;

    logic                             rise, commit;
    logic [2:0]                       addr;
    logic [WIDTH-1:0]                 wdata;
    logic [7:0]                       ctrl;
    logic                             en;
    logic [3:0]                       pre;
    logic [15:0]                      pre_cnt, pre_mask;
    logic                             tick, wrap;
    logic [WIDTH-1:0]                 cnt;
    logic [CHANNELS-1:0][WIDTH-1:0]   shadow, active;
    logic [CHANNELS-1:0]              wr_ch, pwm;
    logic                             hb;
    logic                             unused_bits;

    assign addr     = uio_in[2:0];
    assign wdata    = WIDTH'(scale_duty(ui_in, WIDTH));
    assign en       = ctrl[CTRL_EN_BIT];
    assign pre      = ctrl[CTRL_PRE_MSB:0];
    assign pre_mask = (16'd1 << pre) - 16'd1;
    assign tick     = (pre_cnt & pre_mask) == pre_mask;
    // Wrap only counts while the design actually advances the counter.
    assign wrap     = ena & en & tick & (cnt == DUTY_MAX);
    assign unused_bits = &{1'b0, uio_in[7:4], ctrl[6:4]};

    strobe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (uio_in[3]),
        .rise   (rise)
    );

    for (genvar c = 0; c < CHANNELS; c++) begin : g_dec
        assign wr_ch[c] = commit & (addr == 3'(c));
    end

    // Commit cycle follows the detected edge; ctrl writes land immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit <= 1'b0;
            ctrl   <= '0;
        end else begin
            commit <= rise;
            if (commit && addr == ADDR_CTRL) ctrl <= ui_in;
        end
    end

    // Shadow takes writes any time; active copies shadow only at wrap, with a
    // same-cycle write bypassing straight through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_ch[c]) shadow[c] <= wdata;
                if (wrap)     active[c] <= wr_ch[c] ? wdata : shadow[c];
            end
        end
    end

    // Prescaler and period counter: frozen by ena, parked at 0 when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            cnt     <= '0;
        end else if (ena) begin
            if (!en) begin
                pre_cnt <= '0;
                cnt     <= '0;
            end else if (tick) begin
                pre_cnt <= '0;
                cnt     <= cnt + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 16'd1;
            end
        end
    end

    // Registered PWM compare; all-ones duty is forced high to avoid a dropout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm <= '0;
            hb  <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++)
                pwm[c] <= en & ((active[c] == DUTY_MAX) | (cnt < active[c]));
            if (wrap) hb <= ~hb;
        end
    end

    // Output muxing: everything driven is masked while ena is low.
    always_comb begin
        uio_out = '0;
        if (ena) begin
            uio_out[UIO_WRAP] = wrap;
            uio_out[UIO_ACK]  = commit;
            uio_out[UIO_HB]   = hb;
        end
    end

    assign uo_out = ena ? 8'(pwm) : 8'h00;
    assign uio_oe = UIO_OE_VAL;
endmodule
